// File: rtl/ysyx_22050499_alu_arb_if.sv
// ---------------------------------------------------------------------------
// ysyx_22050499_alu_arb_if
//
// One requester's channel into the shared-ALU arbiter. The channel has two
// halves:
//   request  : req_valid/req_ready handshake carrying the ALU operation
//              (req_srcA, req_srcB, req_subctr, req_opctr, req_brctr)
//   response : resp_valid/resp_ready handshake carrying the captured result
//              (resp_result, resp_br)
//
// Modports:
//   master - the requester (EXU pipe or CSR/aux unit)
//   slave  - the arbiter
// ---------------------------------------------------------------------------
interface ysyx_22050499_alu_arb_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [DATA_WIDTH-1:0] req_srcA;
    logic [DATA_WIDTH-1:0] req_srcB;
    logic                  req_subctr;
    logic [13:0]           req_opctr;
    logic [2:0]            req_brctr;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_result;
    logic                  resp_br;

    modport master (
        output req_valid,
        input  req_ready,
        output req_srcA,
        output req_srcB,
        output req_subctr,
        output req_opctr,
        output req_brctr,
        input  resp_valid,
        output resp_ready,
        input  resp_result,
        input  resp_br
    );

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_srcA,
        input  req_srcB,
        input  req_subctr,
        input  req_opctr,
        input  req_brctr,
        output resp_valid,
        input  resp_ready,
        output resp_result,
        output resp_br
    );
endinterface

// File: rtl/ysyx_22050499_alu_arb.sv
// ---------------------------------------------------------------------------
// ysyx_22050499_alu_arb
//
// Shares one combinational ALU between two requesters:
//   port0 - main EXU pipe
//   port1 - CSR / auxiliary unit
//
// Operations are accepted over valid/ready and granted round-robin (one grant
// per cycle). The winning operation is loaded into an issue register that
// drives the ALU for exactly one cycle; the ALU result is captured on the
// following edge into that requester's one-entry response buffer and handed
// back over valid/ready.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   port0, port1         requester channels (slave side of the interface)
//   alu_srcA/alu_srcB    ALU operands (zero while the issue register is idle)
//   alu_subctr/opctr/brctr  ALU controls (zero while idle)
//   alu_result, alu_br   combinational ALU outputs
//   busy                 issue register valid or any requester slot in use
//
// Latency: request handshake at T -> ALU driven in T+1 -> resp_valid at T+2.
// ---------------------------------------------------------------------------
module ysyx_22050499_alu_arb #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    ysyx_22050499_alu_arb_if.slave port0,
    ysyx_22050499_alu_arb_if.slave port1,
    output logic [DATA_WIDTH-1:0]  alu_srcA,
    output logic [DATA_WIDTH-1:0]  alu_srcB,
    output logic                   alu_subctr,
    output logic [13:0]            alu_opctr,
    output logic [2:0]             alu_brctr,
    input  logic [DATA_WIDTH-1:0]  alu_result,
    input  logic                   alu_br,
    output logic                   busy
);

    typedef enum logic [1:0] {
        SLOT_EMPTY    = 2'd0,
        SLOT_INFLIGHT = 2'd1,
        SLOT_DONE     = 2'd2
    } slot_state_t;

    // Per-requester views of the two interface ports, so the slot logic can
    // be written once and replicated.
    logic                  req_valid_w   [2];
    logic [DATA_WIDTH-1:0] req_srcA_w    [2];
    logic [DATA_WIDTH-1:0] req_srcB_w    [2];
    logic                  req_subctr_w  [2];
    logic [13:0]           req_opctr_w   [2];
    logic [2:0]            req_brctr_w   [2];
    logic                  resp_ready_w  [2];
    logic                  resp_valid_w  [2];
    logic [DATA_WIDTH-1:0] resp_result_w [2];
    logic                  resp_br_w     [2];

    logic [1:0] slot_empty;
    logic [1:0] slot_done;
    logic [1:0] eligible;
    logic [1:0] grant;
    logic       grant_sel;

    // Round-robin pointer: id of the requester granted most recently.
    logic last_reg;

    // Issue register feeding the ALU.
    logic                  issue_valid_reg;
    logic                  issue_id_reg;
    logic [DATA_WIDTH-1:0] issue_srcA_reg;
    logic [DATA_WIDTH-1:0] issue_srcB_reg;
    logic                  issue_subctr_reg;
    logic [13:0]           issue_opctr_reg;
    logic [2:0]            issue_brctr_reg;

    // -----------------------------------------------------------------------
    // Port flattening
    // -----------------------------------------------------------------------
    assign req_valid_w[0]  = port0.req_valid;
    assign req_srcA_w[0]   = port0.req_srcA;
    assign req_srcB_w[0]   = port0.req_srcB;
    assign req_subctr_w[0] = port0.req_subctr;
    assign req_opctr_w[0]  = port0.req_opctr;
    assign req_brctr_w[0]  = port0.req_brctr;
    assign resp_ready_w[0] = port0.resp_ready;

    assign req_valid_w[1]  = port1.req_valid;
    assign req_srcA_w[1]   = port1.req_srcA;
    assign req_srcB_w[1]   = port1.req_srcB;
    assign req_subctr_w[1] = port1.req_subctr;
    assign req_opctr_w[1]  = port1.req_opctr;
    assign req_brctr_w[1]  = port1.req_brctr;
    assign resp_ready_w[1] = port1.resp_ready;

    assign port0.req_ready   = grant[0];
    assign port0.resp_valid  = resp_valid_w[0];
    assign port0.resp_result = resp_result_w[0];
    assign port0.resp_br     = resp_br_w[0];

    assign port1.req_ready   = grant[1];
    assign port1.resp_valid  = resp_valid_w[1];
    assign port1.resp_result = resp_result_w[1];
    assign port1.resp_br     = resp_br_w[1];

    // -----------------------------------------------------------------------
    // Per-requester slot: state machine plus one-entry response buffer
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        slot_state_t           slot_reg;
        logic                  resp_valid_reg;
        logic [DATA_WIDTH-1:0] resp_result_reg;
        logic                  resp_br_reg;
        logic                  capture;

        // The issue register is carrying this requester's operation.
        assign capture = issue_valid_reg && (issue_id_reg == 1'(gi));

        assign slot_empty[gi] = (slot_reg == SLOT_EMPTY);
        assign slot_done[gi]  = (slot_reg == SLOT_DONE);

        // A DONE slot can take a new operation in the same cycle its result
        // is drained, which is what gives back-to-back single-requester use.
        assign eligible[gi] = req_valid_w[gi] &&
                              (slot_empty[gi] || (slot_done[gi] && resp_ready_w[gi]));

        always_ff @(posedge clk) begin
            if (rst) begin
                slot_reg        <= SLOT_EMPTY;
                resp_valid_reg  <= 1'b0;
                resp_result_reg <= '0;
                resp_br_reg     <= 1'b0;
            end else begin
                case (slot_reg)
                    SLOT_EMPTY: begin
                        if (grant[gi]) begin
                            slot_reg <= SLOT_INFLIGHT;
                        end
                    end
                    SLOT_INFLIGHT: begin
                        // An INFLIGHT slot always owns the issue register, so
                        // capture holds here; the guard only documents that.
                        if (capture) begin
                            slot_reg        <= SLOT_DONE;
                            resp_valid_reg  <= 1'b1;
                            resp_result_reg <= alu_result;
                            resp_br_reg     <= alu_br;
                        end
                    end
                    SLOT_DONE: begin
                        // Result buffer holds still until it is consumed.
                        if (resp_ready_w[gi]) begin
                            resp_valid_reg <= 1'b0;
                            slot_reg       <= grant[gi] ? SLOT_INFLIGHT : SLOT_EMPTY;
                        end
                    end
                    default: begin
                        slot_reg       <= SLOT_EMPTY;
                        resp_valid_reg <= 1'b0;
                    end
                endcase
            end
        end

        assign resp_valid_w[gi]  = resp_valid_reg;
        assign resp_result_w[gi] = resp_result_reg;
        assign resp_br_w[gi]     = resp_br_reg;
    end

    // -----------------------------------------------------------------------
    // Round-robin arbitration. Gated by rst so no request handshake is ever
    // reported while the block is being reset.
    // -----------------------------------------------------------------------
    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            if (eligible == 2'b11) begin
                grant = last_reg ? 2'b01 : 2'b10;
            end else begin
                grant = eligible;
            end
        end
    end

    assign grant_sel = grant[1];

    // -----------------------------------------------------------------------
    // Issue register and last-grant pointer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg         <= 1'b1;
            issue_valid_reg  <= 1'b0;
            issue_id_reg     <= 1'b0;
            issue_srcA_reg   <= '0;
            issue_srcB_reg   <= '0;
            issue_subctr_reg <= 1'b0;
            issue_opctr_reg  <= '0;
            issue_brctr_reg  <= '0;
        end else begin
            issue_valid_reg <= |grant;
            if (|grant) begin
                last_reg         <= grant_sel;
                issue_id_reg     <= grant_sel;
                issue_srcA_reg   <= req_srcA_w[grant_sel];
                issue_srcB_reg   <= req_srcB_w[grant_sel];
                issue_subctr_reg <= req_subctr_w[grant_sel];
                issue_opctr_reg  <= req_opctr_w[grant_sel];
                issue_brctr_reg  <= req_brctr_w[grant_sel];
            end
        end
    end

    // ALU sees all-zero controls when idle, so its output is a quiet 0.
    assign alu_srcA   = issue_valid_reg ? issue_srcA_reg   : '0;
    assign alu_srcB   = issue_valid_reg ? issue_srcB_reg   : '0;
    assign alu_subctr = issue_valid_reg ? issue_subctr_reg : 1'b0;
    assign alu_opctr  = issue_valid_reg ? issue_opctr_reg  : '0;
    assign alu_brctr  = issue_valid_reg ? issue_brctr_reg  : '0;

    assign busy = issue_valid_reg || !(&slot_empty);

endmodule

// File: tb/tb_ysyx_22050499_alu_arb.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22050499_alu_arb
//
// Drives both requester channels, supplies a behavioural ALU, and compares
// every cycle against a transaction-level model: each requester has at most
// one outstanding operation whose result becomes visible two cycles after
// its grant; ties are broken against the previous winner.
// ---------------------------------------------------------------------------
module tb_ysyx_22050499_alu_arb;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_22050499_alu_arb_if #(.DATA_WIDTH(DW)) port0_if ();
    ysyx_22050499_alu_arb_if #(.DATA_WIDTH(DW)) port1_if ();

    logic [DW-1:0] alu_srcA, alu_srcB, alu_result;
    logic          alu_subctr, alu_br, busy;
    logic [13:0]   alu_opctr;
    logic [2:0]    alu_brctr;

    ysyx_22050499_alu_arb #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .port0      (port0_if),
        .port1      (port1_if),
        .alu_srcA   (alu_srcA),
        .alu_srcB   (alu_srcB),
        .alu_subctr (alu_subctr),
        .alu_opctr  (alu_opctr),
        .alu_brctr  (alu_brctr),
        .alu_result (alu_result),
        .alu_br     (alu_br),
        .busy       (busy)
    );

    // Requester-side stimulus and observation, indexed by requester.
    logic          v   [2];
    logic [DW-1:0] a   [2];
    logic [DW-1:0] b   [2];
    logic          sub [2];
    logic [13:0]   op  [2];
    logic [2:0]    brc [2];
    logic          rr  [2];
    logic          rdy [2];
    logic          rv  [2];
    logic [DW-1:0] rres[2];
    logic          rbr [2];

    assign port0_if.req_valid  = v[0];
    assign port0_if.req_srcA   = a[0];
    assign port0_if.req_srcB   = b[0];
    assign port0_if.req_subctr = sub[0];
    assign port0_if.req_opctr  = op[0];
    assign port0_if.req_brctr  = brc[0];
    assign port0_if.resp_ready = rr[0];
    assign port1_if.req_valid  = v[1];
    assign port1_if.req_srcA   = a[1];
    assign port1_if.req_srcB   = b[1];
    assign port1_if.req_subctr = sub[1];
    assign port1_if.req_opctr  = op[1];
    assign port1_if.req_brctr  = brc[1];
    assign port1_if.resp_ready = rr[1];
    assign rdy[0]  = port0_if.req_ready;
    assign rv[0]   = port0_if.resp_valid;
    assign rres[0] = port0_if.resp_result;
    assign rbr[0]  = port0_if.resp_br;
    assign rdy[1]  = port1_if.req_ready;
    assign rv[1]   = port1_if.resp_valid;
    assign rres[1] = port1_if.resp_result;
    assign rbr[1]  = port1_if.resp_br;

    // Behavioural ALU (only a few opcode bits are meaningful; others give 0).
    function automatic logic [DW-1:0] ref_alu(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                              input logic s, input logic [13:0] o);
        logic [DW-1:0] r;
        r = '0;
        if (o[0]) r = x & y;
        if (o[1]) r = s ? x - y : x + y;
        if (o[2]) r = x | y;
        if (o[3]) r = x << y[4:0];
        if (o[5]) r = x ^ y;
        return r;
    endfunction

    function automatic logic ref_br(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                    input logic [2:0] c);
        case (c)
            3'd0:    return x == y;
            3'd1:    return x != y;
            3'd2:    return $signed(x) < $signed(y);
            3'd3:    return $signed(x) >= $signed(y);
            3'd4:    return x < y;
            3'd5:    return x >= y;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        alu_result = ref_alu(alu_srcA, alu_srcB, alu_subctr, alu_opctr);
        alu_br     = ref_br(alu_srcA, alu_srcB, alu_brctr);
    end

    // Transaction-level model state.
    bit            m_pend [2];
    int            m_at   [2];
    logic [DW-1:0] m_res  [2];
    logic          m_br   [2];
    bit            m_last;
    bit            m_iv;
    logic [13:0]   m_iop;
    logic [DW-1:0] m_ia;
    int            g_last;
    int            cyc;
    int            n_cmp;
    int            n_err;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Compare all outputs against the model, then advance the model by one
    // cycle using the inputs currently applied.
    task automatic eval();
        bit vis [2];
        bit el  [2];
        int g;
        #1;
        for (int i = 0; i < 2; i++) begin
            vis[i] = m_pend[i] && (cyc >= m_at[i]);
            check_eq($sformatf("resp%0d_valid", i), DW'(rv[i]), DW'(vis[i]));
            if (vis[i]) begin
                check_eq($sformatf("resp%0d_result", i), rres[i], m_res[i]);
                check_eq($sformatf("resp%0d_br", i), DW'(rbr[i]), DW'(m_br[i]));
            end
            el[i] = !rst && v[i] && (!m_pend[i] || (vis[i] && rr[i]));
        end
        g = -1;
        if (el[0] && el[1]) g = m_last ? 0 : 1;
        else if (el[0])     g = 0;
        else if (el[1])     g = 1;
        for (int i = 0; i < 2; i++)
            check_eq($sformatf("req%0d_ready", i), DW'(rdy[i]), DW'(g == i));
        check_eq("alu_opctr", DW'(alu_opctr), m_iv ? DW'(m_iop) : '0);
        check_eq("alu_srcA", alu_srcA, m_iv ? m_ia : '0);
        check_eq("busy", DW'(busy), DW'(m_iv || m_pend[0] || m_pend[1]));

        if (rst) begin
            m_pend[0] = 0; m_pend[1] = 0; m_last = 1; m_iv = 0;
        end else begin
            for (int i = 0; i < 2; i++)
                if (vis[i] && rr[i]) m_pend[i] = 0;
            if (g >= 0) begin
                m_pend[g] = 1;
                m_at[g]   = cyc + 2;
                m_res[g]  = ref_alu(a[g], b[g], sub[g], op[g]);
                m_br[g]   = ref_br(a[g], b[g], brc[g]);
                m_last    = (g == 1);
                m_iv      = 1;
                m_iop     = op[g];
                m_ia      = a[g];
                $display("cycle %0d: req%0d issued op=%h a=%h b=%h sub=%0d brctr=%0d",
                         cyc, g, op[g], a[g], b[g], sub[g], brc[g]);
            end else begin
                m_iv = 0;
            end
        end
        g_last = g;
        cyc++;
    endtask

    task automatic adv();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick();
        eval();
        adv();
    endtask

    task automatic rand_req(input int i);
        a[i]   = $urandom;
        b[i]   = ($urandom_range(0, 3) == 0) ? a[i] : DW'($urandom);
        sub[i] = 1'($urandom_range(0, 1));
        op[i]  = 14'(1) << $urandom_range(0, 13);
        brc[i] = 3'($urandom_range(0, 7));
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] x, input logic [DW-1:0] y,
                           input logic s, input logic [13:0] o, input logic [2:0] c);
        v[i] = 1'b1; a[i] = x; b[i] = y; sub[i] = s; op[i] = o; brc[i] = c;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; g_last = -1;
        m_pend[0] = 0; m_pend[1] = 0; m_at[0] = 0; m_at[1] = 0;
        m_res[0] = '0; m_res[1] = '0; m_br[0] = 0; m_br[1] = 0;
        m_last = 1; m_iv = 0; m_iop = '0; m_ia = '0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            v[i] = 0; a[i] = '0; b[i] = '0; sub[i] = 0; op[i] = '0; brc[i] = '0; rr[i] = 0;
        end
        adv();

        // Reset held with random inputs.
        repeat (3) begin
            for (int i = 0; i < 2; i++) begin
                rand_req(i);
                v[i]  = 1'($urandom_range(0, 1));
                rr[i] = 1'($urandom_range(0, 1));
            end
            eval();
            check_eq("rst_ready0", DW'(rdy[0]), '0);
            check_eq("rst_ready1", DW'(rdy[1]), '0);
            check_eq("rst_result0", rres[0], '0);
            check_eq("rst_result1", rres[1], '0);
            adv();
        end
        rst = 1'b0; v[0] = 0; v[1] = 0; rr[0] = 0; rr[1] = 0;

        // Single add on req0.
        set_req(0, 32'd5, 32'd7, 1'b0, 14'h0002, 3'd0); rr[0] = 1;
        eval(); check_eq("add_ready0", DW'(rdy[0]), 1); adv();
        v[0] = 0;
        eval(); check_eq("add_alu_opctr", DW'(alu_opctr), 32'h2); adv();
        eval(); check_eq("add_valid_t2", DW'(rv[0]), 1); check_eq("add_result", rres[0], 32'd12); adv();
        eval(); check_eq("add_valid_t3", DW'(rv[0]), 0); adv();

        // Tie after reset: req0 wins first, req1 next cycle.
        rst = 1; tick(); rst = 0;
        set_req(0, 32'd3, 32'd5, 1'b1, 14'h0002, 3'd0);
        set_req(1, 32'hF0, 32'hFF, 1'b0, 14'h0020, 3'd0);
        rr[0] = 1; rr[1] = 1;
        eval(); check_eq("tie_ready0", DW'(rdy[0]), 1); check_eq("tie_ready1_t0", DW'(rdy[1]), 0); adv();
        v[0] = 0;
        eval(); check_eq("tie_ready1_t1", DW'(rdy[1]), 1); adv();
        v[1] = 0;
        eval(); check_eq("tie_result0", rres[0], 32'hFFFF_FFFE); adv();
        eval(); check_eq("tie_result1", rres[1], 32'h0000_000F); adv();
        tick();

        // Backpressure on resp0 with the next req0 operation waiting.
        rr[0] = 0;
        set_req(0, 32'd10, 32'd20, 1'b0, 14'h0002, 3'd0);
        eval(); check_eq("bp_ready_t0", DW'(rdy[0]), 1); adv();
        set_req(0, 32'd100, 32'd1, 1'b0, 14'h0020, 3'd0);
        eval(); check_eq("bp_ready_t1", DW'(rdy[0]), 0); adv();
        repeat (4) begin
            eval();
            check_eq("bp_hold_valid", DW'(rv[0]), 1);
            check_eq("bp_hold_result", rres[0], 32'd30);
            check_eq("bp_hold_ready", DW'(rdy[0]), 0);
            adv();
        end
        rr[0] = 1;
        eval();
        check_eq("bp_drain_ready", DW'(rdy[0]), 1);
        check_eq("bp_drain_valid", DW'(rv[0]), 1);
        check_eq("bp_drain_result", rres[0], 32'd30);
        adv();
        v[0] = 0;
        tick();
        eval(); check_eq("bp_next_result", rres[0], 32'd101); adv();
        tick();

        // Branch outcomes on req1.
        rr[1] = 1;
        set_req(1, 32'd9, 32'd9, 1'b1, 14'h0002, 3'd0);
        tick(); v[1] = 0; tick();
        eval(); check_eq("br_eq", DW'(rbr[1]), 1); adv();
        set_req(1, 32'd9, 32'd8, 1'b1, 14'h0002, 3'd1);
        tick(); v[1] = 0; tick();
        eval(); check_eq("br_ne", DW'(rbr[1]), 1); adv();

        // Reset while req0 is INFLIGHT and req1 is DONE.
        rr[0] = 0; rr[1] = 0;
        set_req(1, 32'd1, 32'd2, 1'b0, 14'h0002, 3'd0);
        tick(); v[1] = 0;
        tick();
        set_req(0, 32'd4, 32'd4, 1'b0, 14'h0004, 3'd0);
        tick(); v[0] = 0;
        rst = 1; tick(); rst = 0;
        eval();
        check_eq("mid_rst_valid0", DW'(rv[0]), 0);
        check_eq("mid_rst_valid1", DW'(rv[1]), 0);
        check_eq("mid_rst_busy", DW'(busy), 0);
        adv();
        set_req(0, 32'd6, 32'd1, 1'b0, 14'h0001, 3'd0);
        set_req(1, 32'd6, 32'd1, 1'b0, 14'h0004, 3'd0);
        rr[0] = 1; rr[1] = 1;
        eval(); check_eq("mid_rst_tie_ready0", DW'(rdy[0]), 1); adv();
        v[0] = 0;
        tick(); v[1] = 0;
        repeat (3) tick();

        // Randomized traffic with occasional reset.
        repeat (800) begin
            for (int i = 0; i < 2; i++) begin
                if (!v[i] || g_last == i) begin
                    v[i] = ($urandom_range(0, 99) < 60);
                    if (v[i]) rand_req(i);
                end
                rr[i] = ($urandom_range(0, 99) < 70);
            end
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 0; v[0] = 0; v[1] = 0; rr[0] = 1; rr[1] = 1;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
